// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the synchronous FIFO.
package fifo_pkg;

  // Read-side behaviour selected by the FWFT parameter.
  typedef enum logic {
    MODE_REGISTERED = 1'b0,
    MODE_FWFT       = 1'b1
  } fifo_mode_e;

  // Pointer and occupancy-counter widths derived from the capacity.
  typedef struct packed {
    int ptr_w;
    int cnt_w;
  } fifo_widths_t;

  // Pointers index 0..DEPTH-1; the counter must also represent DEPTH itself.
  function automatic fifo_widths_t fifo_widths(input int depth);
    fifo_widths_t w;
    w.ptr_w = (depth > 1) ? $clog2(depth) : 1;
    w.cnt_w = $clog2(depth + 1);
    return w;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DSIZE, one synchronous write port, one
// asynchronous read port, contents deliberately not reset.
module fifo_mem #(
  parameter int DSIZE = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  logic [DSIZE-1:0] mem_q [DEPTH];

  // Store the write word on an accepted write.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy flags, sticky overflow/underflow and a
// choice of first-word-fall-through or registered read data.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         winc,
  input  logic [DSIZE-1:0]             wdata,
  output logic                         wfull,
  input  logic                         rinc,
  output logic [DSIZE-1:0]             rdata,
  output logic                         rvalid,
  output logic                         rempty,
  output logic                         afull,
  output logic                         aempty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam fifo_widths_t WID  = fifo_widths(DEPTH);
  localparam int           PW   = WID.ptr_w;
  localparam int           CW   = WID.cnt_w;
  localparam fifo_mode_e   MODE = (FWFT != 0) ? MODE_FWFT : MODE_REGISTERED;

  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_TH);
  localparam logic [CW-1:0] CNT_AEMPT = CW'(AEMPTY_TH);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wfull_q, rempty_q, afull_q, aempty_q;
  logic             overflow_q, underflow_q;
  logic             wr_acc_s, rd_acc_s;
  logic [DSIZE-1:0] mem_rdata_s;

  // Requests are accepted only against the registered full/empty state.
  assign wr_acc_s = winc && !wfull_q;
  assign rd_acc_s = rinc && !rempty_q;

  // Next pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc_s) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_acc_s) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy, flag and sticky-error state; flags follow next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      wfull_q     <= 1'b0;
      rempty_q    <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      wfull_q     <= (count_d == CNT_FULL);
      rempty_q    <= (count_d == '0);
      afull_q     <= (count_d >= CNT_AFULL);
      aempty_q    <= (count_d <= CNT_AEMPT);
      overflow_q  <= overflow_q  | (winc & wfull_q);
      underflow_q <= underflow_q | (rinc & rempty_q);
    end
  end

  // Writes presented during reset must not touch storage.
  fifo_mem #(
    .DSIZE (DSIZE),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc_s && !rst),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata_s)
  );

  if (MODE == MODE_FWFT) begin : g_fwft
    // Head word is presented directly; forced to zero while empty so that
    // unwritten storage never leaks out after reset.
    assign rdata  = rempty_q ? '0 : mem_rdata_s;
    assign rvalid = !rempty_q;
  end else begin : g_reg
    logic [DSIZE-1:0] rdata_q;
    logic             rvalid_q;

    // Capture the head word on an accepted read; rvalid flags that one cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc_s;
        if (rd_acc_s) begin
          rdata_q <= mem_rdata_s;
        end
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

  assign wfull     = wfull_q;
  assign rempty    = rempty_q;
  assign afull     = afull_q;
  assign aempty    = aempty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: three configurations (16-deep FWFT, 10-deep FWFT,
// 5-deep registered read) checked every cycle against a queue model.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] winc, rinc;
  logic [7:0] wd [3];

  wire  [2:0] wfull_w, rempty_w, afull_w, aempty_w, ovf_w, unf_w, rvalid_w;
  wire  [7:0] rd_a, rd_b, rd_c;
  wire  [4:0] cnt_a;
  wire  [3:0] cnt_b;
  wire  [2:0] cnt_c;

  int n_pass  = 0;
  int n_total = 0;

  // Model: configuration tables plus one queue per FIFO.
  int         m_dep [3] = '{16, 10, 5};
  int         m_aft [3] = '{12, 7, 3};
  int         m_aet [3] = '{4, 2, 1};
  int         m_fw  [3] = '{1, 1, 0};
  logic [7:0] mq    [3][$];
  bit         m_ovf [3];
  bit         m_unf [3];
  bit         m_rv  [3];
  logic [7:0] m_rd  [3];

  always #5 clk = ~clk;

  sync_fifo #(.DSIZE(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(1)) dut_a (
    .clk(clk), .rst(rst), .winc(winc[0]), .wdata(wd[0]), .wfull(wfull_w[0]),
    .rinc(rinc[0]), .rdata(rd_a), .rvalid(rvalid_w[0]), .rempty(rempty_w[0]),
    .afull(afull_w[0]), .aempty(aempty_w[0]), .count(cnt_a),
    .overflow(ovf_w[0]), .underflow(unf_w[0]));

  sync_fifo #(.DSIZE(8), .DEPTH(10), .AFULL_TH(7), .AEMPTY_TH(2), .FWFT(1)) dut_b (
    .clk(clk), .rst(rst), .winc(winc[1]), .wdata(wd[1]), .wfull(wfull_w[1]),
    .rinc(rinc[1]), .rdata(rd_b), .rvalid(rvalid_w[1]), .rempty(rempty_w[1]),
    .afull(afull_w[1]), .aempty(aempty_w[1]), .count(cnt_b),
    .overflow(ovf_w[1]), .underflow(unf_w[1]));

  sync_fifo #(.DSIZE(8), .DEPTH(5), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(0)) dut_c (
    .clk(clk), .rst(rst), .winc(winc[2]), .wdata(wd[2]), .wfull(wfull_w[2]),
    .rinc(rinc[2]), .rdata(rd_c), .rvalid(rvalid_w[2]), .rempty(rempty_w[2]),
    .afull(afull_w[2]), .aempty(aempty_w[2]), .count(cnt_c),
    .overflow(ovf_w[2]), .underflow(unf_w[2]));

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    else n_pass++;
  endtask

  function automatic int dut_cnt(input int i);
    case (i)
      0:       return int'(cnt_a);
      1:       return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  function automatic int dut_rd(input int i);
    case (i)
      0:       return int'(rd_a);
      1:       return int'(rd_b);
      default: return int'(rd_c);
    endcase
  endfunction

  // Apply the FIFO rules to the inputs seen at this clock edge.
  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      int sz;
      bit wa, ra;
      sz = mq[i].size();
      if (rst) begin
        mq[i].delete();
        m_ovf[i] = 1'b0;
        m_unf[i] = 1'b0;
        m_rv[i]  = 1'b0;
        m_rd[i]  = 8'h00;
      end else begin
        wa = winc[i] && (sz < m_dep[i]);
        ra = rinc[i] && (sz > 0);
        if (winc[i] && !wa) m_ovf[i] = 1'b1;
        if (rinc[i] && !ra) m_unf[i] = 1'b1;
        m_rv[i] = ra;
        if (ra) m_rd[i] = mq[i].pop_front();
        if (wa) mq[i].push_back(wd[i]);
      end
    end
  endtask

  // Compare every output of every FIFO against the model.
  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      int sz;
      sz = mq[i].size();
      chk($sformatf("count%0d", i),  dut_cnt(i),   sz);
      chk($sformatf("wfull%0d", i),  wfull_w[i],   int'(sz == m_dep[i]));
      chk($sformatf("rempty%0d", i), rempty_w[i],  int'(sz == 0));
      chk($sformatf("afull%0d", i),  afull_w[i],   int'(sz >= m_aft[i]));
      chk($sformatf("aempty%0d", i), aempty_w[i],  int'(sz <= m_aet[i]));
      chk($sformatf("ovf%0d", i),    ovf_w[i],     int'(m_ovf[i]));
      chk($sformatf("unf%0d", i),    unf_w[i],     int'(m_unf[i]));
      if (m_fw[i] != 0) begin
        chk($sformatf("rvalid%0d", i), rvalid_w[i], int'(sz != 0));
        if (sz != 0) chk($sformatf("rdata%0d", i), dut_rd(i), int'(mq[i][0]));
      end else begin
        chk($sformatf("rvalid%0d", i), rvalid_w[i], int'(m_rv[i]));
        chk($sformatf("rdata%0d", i),  dut_rd(i),   int'(m_rd[i]));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    winc = 3'b000;
    rinc = 3'b000;
  endtask

  initial begin
    int bias;
    rst = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) wd[i] = 8'h00;
    step();
    step();
    rst = 1'b0;
    chk("rst_count", int'(cnt_a), 0);
    chk("rst_rempty", rempty_w, 3'b111);
    chk("rst_aempty", aempty_w, 3'b111);
    chk("rst_rvalid", rvalid_w, 3'b000);
    chk("rst_rdata_a", int'(rd_a), 0);
    chk("rst_rdata_c", int'(rd_c), 0);

    // Fill the 16-deep FIFO, then one write too many.
    for (int i = 0; i < 16; i++) begin
      winc[0] = 1'b1;
      wd[0]   = 8'(i);
      step();
      if (i == 10) chk("afull_at11", afull_w[0], 0);
      if (i == 11) chk("afull_at12", afull_w[0], 1);
    end
    chk("full_count", int'(cnt_a), 16);
    chk("full_flag", wfull_w[0], 1);
    wd[0] = 8'hEE;
    step();
    chk("overflow", ovf_w[0], 1);
    chk("ovf_count", int'(cnt_a), 16);
    idle();

    // Drain: data in write order, aempty at count 4, then underflow.
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", int'(rd_a), i);
      rinc[0] = 1'b1;
      step();
      if (i == 10) chk("aempty_at5", aempty_w[0], 0);
      if (i == 11) chk("aempty_at4", aempty_w[0], 1);
    end
    chk("drain_empty", rempty_w[0], 1);
    step();
    chk("underflow", unf_w[0], 1);
    idle();

    // 10-deep FIFO: keep 3 words in flight across many pointer wraps.
    for (int i = 0; i < 3; i++) begin
      winc[1] = 1'b1;
      wd[1]   = 8'(8'h30 + i);
      step();
    end
    for (int i = 0; i < 25; i++) begin
      chk("wrap_head", int'(rd_b), (i < 3) ? (8'h30 + i) : (8'h40 + i - 3));
      winc[1] = 1'b1;
      rinc[1] = 1'b1;
      wd[1]   = 8'(8'h40 + i);
      step();
      chk("wrap_count", int'(cnt_b), 3);
    end
    idle();

    // Simultaneous read+write when full, then when empty.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      winc[0] = 1'b1;
      wd[0]   = 8'(8'h50 + i);
      step();
    end
    rinc[0] = 1'b1;
    wd[0]   = 8'hBB;
    step();
    chk("full_both_count", int'(cnt_a), 15);
    chk("full_both_ovf", ovf_w[0], 1);
    chk("full_both_unf", unf_w[0], 0);
    winc[0] = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("emptied", rempty_w[0], 1);
    winc[0] = 1'b1;
    wd[0]   = 8'hCC;
    step();
    chk("empty_both_count", int'(cnt_a), 1);
    chk("empty_both_unf", unf_w[0], 1);
    chk("empty_both_data", int'(rd_a), 8'hCC);
    idle();

    // Reset mid-operation with a write pending: everything discarded.
    for (int i = 0; i < 5; i++) begin
      winc[0] = 1'b1;
      wd[0]   = 8'(8'h60 + i);
      step();
    end
    rst   = 1'b1;
    wd[0] = 8'h99;
    step();
    rst = 1'b0;
    chk("srst_count", int'(cnt_a), 0);
    chk("srst_rempty", rempty_w[0], 1);
    chk("srst_ovf", ovf_w[0], 0);
    chk("srst_unf", unf_w[0], 0);
    wd[0] = 8'h77;
    step();
    winc[0] = 1'b0;
    chk("post_rst_data", int'(rd_a), 8'h77);
    chk("post_rst_count", int'(cnt_a), 1);
    rinc[0] = 1'b1;
    step();
    idle();

    // Registered-read FIFO: one-cycle rvalid pulse carrying 0xA5.
    winc[2] = 1'b1;
    wd[2]   = 8'hA5;
    step();
    winc[2] = 1'b0;
    chk("reg_rvalid_before", rvalid_w[2], 0);
    rinc[2] = 1'b1;
    step();
    rinc[2] = 1'b0;
    chk("reg_rvalid", rvalid_w[2], 1);
    chk("reg_rdata", int'(rd_c), 8'hA5);
    step();
    chk("reg_rvalid_drop", rvalid_w[2], 0);
    chk("reg_rdata_hold", int'(rd_c), 8'hA5);

    // Random traffic with phases biased toward filling or draining.
    bias = 70;
    for (int n = 0; n < 1200; n++) begin
      if ((n % 150) == 0) bias = 100 - bias;
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 3; i++) begin
        winc[i] = ($urandom_range(0, 99) < bias);
        rinc[i] = ($urandom_range(0, 99) < (100 - bias));
        wd[i]   = 8'($urandom);
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, word capacity; any integer >=2, power of two not required.
REQ-003 SHALL have parameter AFULL_TH, default 12; almost-full threshold, 1..DEPTH-1.
REQ-004 SHALL have parameter AEMPTY_TH, default 4; almost-empty threshold, 1..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 1; 1 = first-word-fall-through, 0 = registered-read mode.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 winc  input  1  write request.
REQ-010 wdata  input  DSIZE  write data.
REQ-011 wfull  output  1  FIFO holds DEPTH words.
REQ-012 rinc  input  1  read request / pop.
REQ-013 rdata  output  DSIZE  read data.
REQ-014 rvalid  output  1  rdata valid qualifier.
REQ-015 rempty  output  1  FIFO holds 0 words.
REQ-016 afull  output  1  count >= AFULL_TH.
REQ-017 aempty  output  1  count <= AEMPTY_TH.
REQ-018 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-019 overflow  output  1  sticky: write attempted while full.
REQ-020 underflow  output  1  sticky: read attempted while empty.

Function
REQ-021 Write accepted iff winc && !wfull; accepted word stored at wptr, wptr advances.
REQ-022 Read accepted iff rinc && !rempty; rptr advances.
REQ-023 wptr/rptr range 0..DEPTH-1; increment from DEPTH-1 wraps to 0 (no binary overflow reliance).
REQ-024 count next = count + wr_acc - rd_acc; simultaneous accepted read and write leave count unchanged.
REQ-025 When full, winc+rinc same cycle: only read accepted, count becomes DEPTH-1, overflow set.
REQ-026 When empty, winc+rinc same cycle: only write accepted, count becomes 1, underflow set.
REQ-027 wfull, rempty, afull, aempty, count registered, derived from next count; valid in the cycle after the causing edge.
REQ-028 FWFT=1: rdata = word at rptr combinationally from storage; rvalid = !rempty; first written word visible one cycle after its write edge.
REQ-029 FWFT=0: accepted read registers word at rptr into rdata; rvalid high exactly one cycle after each accepted read, else low; rdata holds last value otherwise.
REQ-030 overflow/underflow set on the edge after the offending request; cleared only by rst.
REQ-031 Storage contents never altered by rejected writes.

Reset
REQ-032 rst high at a rising edge SHALL force: wptr=0, rptr=0, count=0, rempty=1, aempty=1, wfull=0, afull=0, rvalid=0, rdata=0, overflow=0, underflow=0.
REQ-033 rst mid-operation SHALL discard all stored words; storage array itself need not be cleared.
REQ-034 winc/rinc during rst cycle SHALL be ignored.

Structure
REQ-035 fifo_pkg SHALL hold the mode enum (FWFT / REGISTERED) and a function computing pointer width and count width from DEPTH.
REQ-036 Storage SHALL be one sub-module, fifo_mem: DEPTH x DSIZE, one write port, one asynchronous read port, no reset.
REQ-037 Pointer, count, flag and sticky logic SHALL live in sync_fifo; no other sub-modules.

Verification
REQ-038 DEPTH=16, rst then 16 writes 0x00..0x0F -> wfull=1, count=16, afull=1 from write 12; 17th write -> overflow=1, data unchanged.
REQ-039 Drain all 16 (FWFT=1) -> rdata sequence 0x00..0x0F, rempty=1 after last, aempty=1 at count<=4; extra read -> underflow=1.
REQ-040 DEPTH=10, 25 write/read pairs offset by 3 words -> pointers wrap at 9->0, data order preserved, count steady at 3.
REQ-041 Full FIFO, winc+rinc same cycle -> count=15, overflow=1; empty FIFO, winc+rinc -> count=1, underflow=1.
REQ-042 FWFT=0: write 0xA5, read -> rvalid pulses one cycle after rinc with rdata=0xA5.
REQ-043 Write 5 words, assert rst one cycle with winc=1 -> count=0, rempty=1, flags/stickies cleared; next read returns newly written data only.
